// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a combinational product and skip RUN.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int          CNT_W   = $clog2(XLEN);
    localparam logic [2:0]  OP_MTHI = 3'd4;
    localparam logic [2:0]  OP_MTLO = 3'd5;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    count_r;
    logic [XLEN-1:0]     a_r, b_r, rem_r, hi_r, lo_r;
    logic [2*XLEN-1:0]   acc_r;
    logic                sa_r, sb_r, is_div_r, div_zero_r, busy_r, done_r;

    logic                accept_s, muldiv_s, mt_s, div_zero_s, fast_mul_s, sa_s, sb_s;
    logic [XLEN:0]       mul_sum_s, div_shift_s;
    logic                div_ge_s;
    logic [XLEN-1:0]     div_sub_s, res_hi_s, res_lo_s;
    logic [2*XLEN-1:0]   prod_raw_s, prod_s;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ({XLEN{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? ({(2*XLEN){1'b0}} - v) : v;
    endfunction

    // Request decode; ops 6/7 are never accepted.
    always_comb begin
        accept_s   = (state_r == IDLE) && start && (op <= OP_MTLO);
        muldiv_s   = accept_s && !op[2];
        mt_s       = accept_s && op[2];
        sa_s       = !op[0] && src_a[XLEN-1];
        sb_s       = !op[0] && src_b[XLEN-1];
        div_zero_s = muldiv_s && op[1] && (src_b == {XLEN{1'b0}});
`ifdef MULDIV_FAST_MUL_EN
        fast_mul_s = muldiv_s && !op[1];
`else
        fast_mul_s = 1'b0;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (muldiv_s) begin
                    if (div_zero_s || fast_mul_s) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == CNT_W'(XLEN - 1)) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Iteration datapath and sign-corrected results.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        div_shift_s = {rem_r, acc_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_r});
        // The true difference is below the divisor, so XLEN bits suffice.
        div_sub_s   = div_shift_s[XLEN-1:0] - b_r;
`ifdef MULDIV_FAST_MUL_EN
        prod_raw_s  = {{XLEN{1'b0}}, a_r} * {{XLEN{1'b0}}, b_r};
`else
        prod_raw_s  = acc_r;
`endif
        prod_s      = cond_neg_w(prod_raw_s, sa_r ^ sb_r);
        if (div_zero_r) begin
            res_hi_s = a_r;
            res_lo_s = {XLEN{1'b1}};
        end else if (is_div_r) begin
            res_hi_s = cond_neg(rem_r, sa_r);
            res_lo_s = cond_neg(acc_r[XLEN-1:0], sa_r ^ sb_r);
        end else begin
            res_hi_s = prod_s[2*XLEN-1:XLEN];
            res_lo_s = prod_s[XLEN-1:0];
        end
    end

    // Operand latches, accumulators, HI/LO and handshake registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r    <= {CNT_W{1'b0}};
            a_r        <= {XLEN{1'b0}};
            b_r        <= {XLEN{1'b0}};
            rem_r      <= {XLEN{1'b0}};
            acc_r      <= {(2*XLEN){1'b0}};
            sa_r       <= 1'b0;
            sb_r       <= 1'b0;
            is_div_r   <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {XLEN{1'b0}};
            lo_r       <= {XLEN{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mt_s) begin
                        if (op == OP_MTHI) begin
                            hi_r <= src_a;
                        end else begin
                            lo_r <= src_a;
                        end
                        done_r <= 1'b1;
                    end else if (muldiv_s) begin
                        busy_r     <= 1'b1;
                        count_r    <= {CNT_W{1'b0}};
                        sa_r       <= sa_s;
                        sb_r       <= sb_s;
                        is_div_r   <= op[1];
                        div_zero_r <= div_zero_s;
                        // Divide-by-zero keeps the raw dividend for HI.
                        a_r        <= div_zero_s ? src_a : cond_neg(src_a, sa_s);
                        b_r        <= cond_neg(src_b, sb_s);
                        acc_r      <= {{XLEN{1'b0}}, cond_neg(src_a, sa_s)};
                        rem_r      <= {XLEN{1'b0}};
                    end
                end
                RUN: begin
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (is_div_r) begin
                        rem_r <= div_ge_s ? div_sub_s : div_shift_s[XLEN-1:0];
                        acc_r <= {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-2:0], div_ge_s};
                    end else begin
                        acc_r <= {mul_sum_s, acc_r[XLEN-1:1]};
                    end
                end
                FIX: begin
                    hi_r   <= res_hi_s;
                    lo_r   <= res_lo_s;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, monitor pops on each done pulse.
module tb_mul_div_unit;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = 33;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy_cycles;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mul_div_unit #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares HI/LO and busy length on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(done_cnt), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                    check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                    check({e.name, "_busy"}, 64'(busy_cnt), 64'(e.busy_cycles));
                end
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
            end
        end
    end

    task automatic push(input logic [31:0] eh, input logic [31:0] el, input int bc, input string nm);
        exp_t e;
        e.hi = eh; e.lo = el; e.busy_cycles = bc; e.name = nm;
        sb_q.push_back(e);
        m_hi = eh; m_lo = el;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int bc, input string nm);
        push(eh, el, bc, nm);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check({nm, "_timeout"}, 64'(sb_q.size()), 64'(0));
            sb_q.delete();
        end
    endtask

    initial begin
        int saved;
        int n;
        repeat (3) @(negedge clk);
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_busy_done", 64'({busy, done}), 64'(0));
        reset_n = 1'b1;

        issue(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_BUSY, "mult_m3x5");
        drain("mult_m3x5");
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_BUSY, "multu_max");
        drain("multu_max");
        issue(OP_MULT,  32'hFFFF_FFFE, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, MUL_BUSY, "mult_negneg");
        drain("mult_negneg");
        issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_m7by2");
        drain("div_m7by2");
        issue(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, "div_7bym2");
        drain("div_7bym2");
        issue(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33, "divu_max");
        drain("divu_max");
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, "div_ovf");
        drain("div_ovf");
        issue(OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1, "divu_by0");
        drain("divu_by0");
        issue(OP_DIV,   32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1, "div_by0_neg");
        drain("div_by0_neg");

        // MTHI then MTLO on consecutive cycles.
        push(32'hA5A5_A5A5, m_lo, 0, "mthi");
        push(32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, "mtlo");
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; src_a = 32'hA5A5_A5A5;
        @(negedge clk);
        op = OP_MTLO; src_a = 32'h5A5A_5A5A;
        @(negedge clk);
        start = 1'b0;
        drain("mt_pair");

        // Reserved ops are never accepted.
        saved = done_cnt;
        @(negedge clk);
        start = 1'b1; op = 3'd6; src_a = 32'h1111_1111;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("reserved_no_done", 64'(done_cnt), 64'(saved));
        check("reserved_hi", 64'(hi), 64'(32'hA5A5_A5A5));

        // Second start during a busy operation is ignored.
        saved = done_cnt;
`ifdef MULDIV_FAST_MUL_EN
        issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, "busy_op");
`else
        issue(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 33, "busy_op");
`endif
        repeat (9) @(negedge clk);
        start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        drain("busy_op");
        repeat (5) @(negedge clk);
        check("single_done", 64'(done_cnt), 64'(saved + 1));
        check("ignored_start_hi", 64'(hi), 64'(m_hi));

        // Back-to-back: next start accepted in the done cycle.
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MUL_BUSY, "b2b_mul");
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_wait", 64'(done), 64'(1));
        push(32'h0000_0000, 32'h0000_0064, 33, "b2b_div");
        start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd10;
        @(negedge clk);
        start = 1'b0;
        drain("b2b");

        // Reset in the middle of a DIV.
        issue(OP_MTHI, 32'h1111_1111, 32'h0, 32'h1111_1111, m_lo, 0, "mthi_pre");
        drain("mthi_pre");
        saved = done_cnt;
        @(negedge clk);
        start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'(1));
        reset_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_hi", 64'(hi), 64'(0));
        check("midreset_lo", 64'(lo), 64'(0));
        busy_cnt = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset_no_done", 64'(done_cnt), 64'(saved));
        check("post_reset_hilo", {hi, lo}, 64'(0));

        // Unit recovers after reset.
        issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, "post_reset_divu");
        drain("post_reset_divu");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative HI/LO multiply/divide unit, directly downstream of the 32x32 register file.
- Consumes the two register read operands and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers; MFHI/MFLO read them through the hi/lo outputs.
- Start/busy/done handshake with the pipeline control.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits. Only 32 is required to be supported.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved
- src_a  input  XLEN  register-file rdata1 (rs)
- src_b  input  XLEN  register-file rdata2 (rt)
- busy  output  1  operation in progress; start ignored while high
- done  output  1  one-cycle pulse when HI/LO updated
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register

Behaviour:
- Reset (async, any time, including mid-operation):
  - hi=0, lo=0, busy=0, done=0; state=IDLE; counter and operand latches cleared; any in-flight operation discarded.
- States: IDLE, RUN, FIX.
- Accept edge T0: IDLE with start=1 and op in 0..5.
  - op 6/7 is never accepted: no state change, done stays 0.
  - start while busy=1 is ignored and not queued.
- MTHI/MTLO:
  - At T0, hi (or lo) <= src_a; other register unchanged.
  - done=1 in the cycle after T0; busy never asserts; state stays IDLE.
- MULT/MULTU/DIV/DIVU:
  - At T0, latch operands. For signed ops latch magnitudes plus sign bits sa=src_a[31], sb=src_b[31].
  - At T0, go to RUN with count=0; busy=1.
  - RUN performs one iteration per edge, T1..T32, count 0..31.
  - Multiply: shift-add, 64-bit product accumulator.
  - Divide: restoring, 1 quotient bit per edge, 33-bit partial remainder.
  - After the count=31 iteration, go to FIX.
  - Edge T33 (FIX):
    - Apply sign correction: product negated if sa^sb; quotient negated if sa^sb; remainder negated if sa.
    - Write hi/lo, state=IDLE, busy=0, done=1 for that one cycle.
  - busy is high for 33 cycles; done is high for exactly 1 cycle.
  - Back-to-back: a new start may be accepted in the done cycle.
- Results:
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder. Truncation toward zero; remainder takes the sign of the dividend.
- Divide by zero (DIV/DIVU with src_b=0):
  - Detected at T0; RUN is skipped and the next state is FIX.
  - At T1: hi=src_a, lo=32'hFFFFFFFF, done=1 in the cycle after T1.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0, no exception, normal 33-cycle latency.
- hi/lo hold their values except on a write edge. Outputs are registered.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN
- Defined:
  - MULT/MULTU compute the full 64-bit product combinationally from the latched operands and skip RUN (T0 -> FIX).
  - hi/lo are written at T1; done=1 in the cycle after T1; busy is high for 1 cycle.
  - Divide behaviour is unchanged.
- Undefined: multiplies use the 32-iteration path, 33-cycle busy as above.
- Both builds must produce identical hi/lo values for the same inputs.

Test Plan:
- Reset then MULT, src_a=0xFFFFFFFD (-3), src_b=5:
  - busy high 33 cycles (1 with MULDIV_FAST_MUL_EN);
  - done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU, src_a=src_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU, src_a=0xFFFFFFFF, src_b=0x10 -> lo=0x0FFFFFFF, hi=0x0000000F.
- DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 by 0 -> done in the cycle after T1; hi=0x1234, lo=0xFFFFFFFF.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A on consecutive cycles:
  - hi/lo updated, busy=0 throughout.
  - Then start MULT while busy and pulse start again at cycle 10 of the MULT: the second start is ignored (single done).
  - Assert reset_n=0 at cycle 15 of a DIV: immediately busy=0, hi=lo=0, no done.
